// File: rtl/one_wire_pkg.sv
// Shared types and CRC-8 constants for the 1-wire scratchpad and ROM logic.
// No clocked logic lives here.
package one_wire_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CRC  = 2'd2
  } ow_state_t;

  // Dallas/Maxim CRC-8 (x^8+x^5+x^4+1), reflected form, bytes shifted LSB first.
  localparam logic [7:0] OW_CRC8_POLY = 8'h8C;
  localparam logic [7:0] OW_CRC8_INIT = 8'h00;

endpackage

// File: rtl/one_wire_crc8.sv
// Next-state CRC-8 for one byte, LSB first; purely combinational (0 cycles).
// No flow control: the caller decides when to register crc_out.
module one_wire_crc8
  import one_wire_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = {1'b0, c[7:1]} ^ (((c[0] ^ byte_in[i]) != 1'b0) ? OW_CRC8_POLY : 8'h00);
    end
    crc_out = c;
  end

endmodule

// File: rtl/one_wire_burst_ram.sv
// Scratchpad RAM: single-word writes, burst reads at one word/cycle, optional CRC-8 tail beat.
// First beat one cycle after request; requests arriving while busy are dropped, not queued.
module one_wire_burst_ram
  import one_wire_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CRC_EN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_address,
  input  logic [ADDR_W:0]   read_len,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_dv,
  output logic              data_last,
  output logic              crc_beat
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  ow_state_t         state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   len_eff;
  logic [7:0]        crc;
  logic [7:0]        crc_next;
  logic [7:0]        crc_byte;
  logic [DATA_W-1:0] rd_word;

  // Combinational read of the pre-edge array gives read-first collision behaviour.
  assign rd_word  = mem[ptr];
  assign crc_byte = 8'(rd_word);
  assign len_eff  = (read_len > LEN_MAX) ? LEN_MAX : read_len;

  one_wire_crc8 u_crc8 (
    .crc_in  (crc),
    .byte_in (crc_byte),
    .crc_out (crc_next)
  );

  // Kept free of reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (reset && write) begin
      mem[write_address] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      remaining <= '0;
      crc       <= OW_CRC8_INIT;
      busy      <= 1'b0;
      data_out  <= '0;
      data_dv   <= 1'b0;
      data_last <= 1'b0;
      crc_beat  <= 1'b0;
    end else begin
      data_dv   <= 1'b0;
      data_last <= 1'b0;
      crc_beat  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (read_en && (read_len != '0)) begin
            ptr       <= read_address;
            remaining <= len_eff;
            crc       <= OW_CRC8_INIT;
            busy      <= 1'b1;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          data_out  <= rd_word;
          data_dv   <= 1'b1;
          crc       <= crc_next;
          ptr       <= ptr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
          if (remaining == (ADDR_W+1)'(1)) begin
            if (CRC_EN != 0) begin
              state <= ST_CRC;
            end else begin
              data_last <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        ST_CRC: begin
          data_out  <= DATA_W'(crc);
          data_dv   <= 1'b1;
          crc_beat  <= 1'b1;
          data_last <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/one_wire_burst_ram.md
Name: one_wire_burst_ram

Overview:
- Parametrised scratchpad RAM for the 1-wire controller.
- Control logic writes single words; the 1-wire interface requests multi-word burst reads.
- Reads stream back one word per cycle with valid/last flags.
- Optional trailing Dallas/Maxim CRC-8 beat lets the bus side append a check byte to ROM/scratchpad transfers without a separate CRC engine.

Parameters:
- DATA_W, 8: word width; must be 8 when CRC_EN=1.
- DEPTH, 32: number of words; must be a power of 2, ≥2.
- ADDR_W, $clog2(DEPTH): address width (derived, not overridden).
- CRC_EN, 0: 1 appends a CRC-8 beat after each burst.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- write  in  1  write strobe.
- write_address  in  ADDR_W  write word address.
- data_in  in  DATA_W  write data.
- read_en  in  1  burst request; sampled only in IDLE.
- read_address  in  ADDR_W  burst start address.
- read_len  in  ADDR_W+1  burst length in words, 1..DEPTH.
- busy  out  1  burst in progress; requests ignored while high.
- data_out  out  DATA_W  read data or CRC value.
- data_dv  out  1  data_out valid, one cycle per beat.
- data_last  out  1  high with data_dv on the final beat.
- crc_beat  out  1  high with data_dv when data_out carries the CRC.

Behaviour:
- Reset (reset==0 at edge):
  - State goes to IDLE; busy, data_dv, data_last, crc_beat, data_out and the CRC accumulator clear to 0.
  - Memory contents are NOT cleared, so the array stays BRAM-inferrable.
  - Reset mid-burst aborts the burst: no further beats, and no data_last/CRC for it.
- Write port:
  - write==1 stores data_in at write_address at the edge, in every state.
  - Write is independent of reset state except during reset itself, when writes are blocked.
- Read collision:
  - Read-first. A write and a burst read to the same address in the same cycle returns the OLD word.
  - The new word is visible from the next cycle.
- States:
  - IDLE: if read_en && read_len!=0, latch ptr=read_address and remaining=read_len, clear CRC, busy<=1, go to READ. read_len==0 is ignored and the block stays in IDLE.
  - READ, each cycle:
    - data_out<=mem[ptr], data_dv<=1.
    - CRC updates with that word.
    - ptr<=ptr+1 modulo DEPTH (wraps DEPTH-1 to 0).
    - remaining decrements.
    - When remaining==1: if CRC_EN, go to CRC with data_last<=0; else data_last<=1, busy<=0, go to IDLE.
  - CRC (CRC_EN=1 only), one cycle: data_out<=crc including the final word, data_dv<=1, crc_beat<=1, data_last<=1, busy<=0, go to IDLE.
- Latency and rate:
  - read_en sampled at edge N; first beat is visible after edge N+1.
  - Beats are back-to-back; burst of L words occupies L cycles, plus 1 cycle with CRC_EN.
  - busy rises after edge N and falls with the last beat.
  - The next request is accepted at the edge following the last beat.
  - Outputs default to 0 in any cycle with no beat; data_out holds its last value.
- CRC-8:
  - Polynomial x^8+x^5+x^4+1, reflected constant 8'h8C, init 0x00.
  - Bytes are processed LSB first, Maxim 1-wire convention.
- read_en while busy is dropped; it is not queued.
- read_len>DEPTH is clamped to DEPTH.

Decomposition:
- Package one_wire_pkg:
  - State encoding localparams: ST_IDLE, ST_READ, ST_CRC.
  - OW_CRC8_POLY = 8'h8C.
  - OW_CRC8_INIT = 8'h00.
- Sub-module one_wire_crc8: combinational next-CRC from (crc_in, byte_in), eight unrolled shift/xor steps. It is reused later by the bus-side ROM search logic.

Test Plan:
- Basic burst: write 0xA0,0xA1,0xA2,0xA3 to addr 0..3, then read_en addr 0 len 4 → data_dv on 4 consecutive cycles, data_out A0,A1,A2,A3, data_last only on A3, busy high exactly 4 cycles.
- Wrap: DEPTH=32, mem[30]=0x11, mem[31]=0x22, mem[0]=0x33, mem[1]=0x44; read addr 30 len 4 → 11,22,33,44.
- CRC (CRC_EN=1): load 02,1C,B8,01,00,00,00 at addr 0; read len 7 → 7 data beats, then 8th beat data_out=0xA2 with crc_beat=1 and data_last=1.
- Rejects:
  - read_len=0 → busy stays 0, no data_dv.
  - read_en asserted mid-burst → ignored; burst length unchanged, no extra beats afterwards.
- Collision: mem[5]=0x55; during a burst, write 0x99 to addr 5 in the cycle ptr=5 → beat returns 0x55; a subsequent read of addr 5 returns 0x99.
- Reset mid-burst: assert reset (low) on the 2nd beat of a len-8 burst → next cycle data_dv=0, busy=0, no data_last. After release, memory contents are intact and a fresh burst returns the original data.
